// File: rtl/msg_dispatch_fifo_if.sv
// ---------------------------------------------------------------------------
// msg_dispatch_fifo_if
//   Bundle between the ITCH parser, the dispatch FIFO and the order-book stage.
//   master : parser/consumer side (drives in_* and out_ready)
//   slave  : dispatch FIFO side (drives out_*, fifo_level and the statistics)
//   in_done/in_msg_type/in_stock_id/in_order_id/in_price/in_quantity : parsed message
//   out_valid/out_ready : show-ahead head handshake
//   out_kind/out_stock_id/out_order_id/out_price/out_quantity : head entry
//   fifo_level/drop_count/bad_type_count : occupancy and saturating statistics
// ---------------------------------------------------------------------------
interface msg_dispatch_fifo_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    logic                     in_done;
    logic [7:0]               in_msg_type;
    logic [7:0]               in_stock_id;
    logic [31:0]              in_order_id;
    logic [31:0]              in_price;
    logic [31:0]              in_quantity;
    logic                     out_valid;
    logic                     out_ready;
    logic [1:0]               out_kind;
    logic [7:0]               out_stock_id;
    logic [31:0]              out_order_id;
    logic [31:0]              out_price;
    logic [31:0]              out_quantity;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic [CNT_W-1:0]         drop_count;
    logic [CNT_W-1:0]         bad_type_count;

    modport master (
        output in_done, in_msg_type, in_stock_id, in_order_id, in_price, in_quantity,
        output out_ready,
        input  out_valid, out_kind, out_stock_id, out_order_id, out_price, out_quantity,
        input  fifo_level, drop_count, bad_type_count
    );

    modport slave (
        input  in_done, in_msg_type, in_stock_id, in_order_id, in_price, in_quantity,
        input  out_ready,
        output out_valid, out_kind, out_stock_id, out_order_id, out_price, out_quantity,
        output fifo_level, drop_count, bad_type_count
    );
endinterface

// File: rtl/msg_dispatch_fifo.sv
// ---------------------------------------------------------------------------
// msg_dispatch_fifo
//   Captures each completed parsed message one cycle after the parser's done
//   pulse, validates and classifies the type byte, and buffers accepted
//   messages in a show-ahead FIFO read through a valid/ready handshake.
//   Unknown types and messages arriving into a full, non-draining FIFO are
//   discarded and counted in saturating counters.
// Ports
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : msg_dispatch_fifo_if.slave (parser inputs, head outputs, stats)
// ---------------------------------------------------------------------------
module msg_dispatch_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    msg_dispatch_fifo_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 2 + 8 + 32 + 32 + 32;

    // Returns {known, kind[1:0]} for a message type byte.
    function automatic logic [2:0] classify(input logic [7:0] msg_type);
        logic [2:0] res;
        case (msg_type)
            8'h41:   res = 3'b100;  // 'A' add
            8'h44:   res = 3'b101;  // 'D' delete
            8'h45:   res = 3'b110;  // 'E' execute
            8'h58:   res = 3'b111;  // 'X' cancel
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    logic                 done_q;
    logic [LVL_W-1:0]     level_q,    level_d;
    logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [ENT_W-1:0]     mem_q [DEPTH];
    logic [ENT_W-1:0]     head_q,     head_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]     bad_cnt_q,  bad_cnt_d;

    logic [2:0]           cls_s;
    logic [ENT_W-1:0]     entry_s;
    logic [PTR_W-1:0]     rd_next_s;
    logic                 full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 bad_s;

    // Classification, push/pop decisions and next-state for pointers and level.
    always_comb begin
        cls_s     = classify(bus.in_msg_type);
        entry_s   = {cls_s[1:0], bus.in_stock_id, bus.in_order_id, bus.in_price, bus.in_quantity};
        full_s    = (level_q == LVL_W'(DEPTH));
        pop_s     = out_valid_q && bus.out_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_s    = done_q && cls_s[2] && (!full_s || pop_s);
        drop_s    = done_q && cls_s[2] && full_s && !pop_s;
        bad_s     = done_q && !cls_s[2];
        rd_next_s = rd_ptr_q + PTR_W'(1);

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_next_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        out_valid_d = (level_d != {LVL_W{1'b0}});
    end

    // Next head register: the registered copy of the entry at the read pointer.
    always_comb begin
        head_d = head_q;
        if (pop_s) begin
            // With two or more stored, the successor is already in memory
            // (DEPTH >= 2, so a same-edge push never targets it).
            if (level_q >= LVL_W'(2)) begin
                head_d = mem_q[rd_next_s];
            end else if (push_s) begin
                head_d = entry_s;
            end else begin
                head_d = head_q;  // emptied: hold last value
            end
        end else if ((level_q == {LVL_W{1'b0}}) && push_s) begin
            head_d = entry_s;
        end else begin
            head_d = head_q;
        end
    end

    // Saturating statistics counters.
    always_comb begin
        if (drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
        if (bad_s && (bad_cnt_q != {CNT_W{1'b1}})) begin
            bad_cnt_d = bad_cnt_q + CNT_W'(1);
        end else begin
            bad_cnt_d = bad_cnt_q;
        end
    end

    // Control, head and statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q      <= 1'b0;
            level_q     <= {LVL_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            head_q      <= {ENT_W{1'b0}};
            out_valid_q <= 1'b0;
            drop_cnt_q  <= {CNT_W{1'b0}};
            bad_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            // Parser fields settle on the done edge, so sampling waits one cycle.
            done_q      <= bus.in_done;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
            drop_cnt_q  <= drop_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    // FIFO storage; written at the tail on every accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENT_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_kind       = head_q[ENT_W-1 -: 2];
    assign bus.out_stock_id   = head_q[103:96];
    assign bus.out_order_id   = head_q[95:64];
    assign bus.out_price      = head_q[63:32];
    assign bus.out_quantity   = head_q[31:0];
    assign bus.fifo_level     = level_q;
    assign bus.drop_count     = drop_cnt_q;
    assign bus.bad_type_count = bad_cnt_q;
endmodule

// File: tb/tb_msg_dispatch_fifo.sv
// ---------------------------------------------------------------------------
// tb_msg_dispatch_fifo
//   Scoreboard bench for msg_dispatch_fifo: expected head entries are queued
//   when a message is driven and compared at the negative edge whenever the
//   DUT presents out_valid; per-scenario tasks check latency, level and stats.
// ---------------------------------------------------------------------------
module tb_msg_dispatch_fifo;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [7:0]  typ;
        logic [7:0]  stock;
        logic [31:0] order;
        logic [31:0] price;
        logic [31:0] qty;
    } msg_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  stock;
        logic [31:0] order;
        logic [31:0] price;
        logic [31:0] qty;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;
    exp_t got_e;
    msg_t pend = '0;
    logic [7:0] good_types [4] = '{8'h41, 8'h44, 8'h45, 8'h58};

    always #5 clk = ~clk;

    msg_dispatch_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus_if ();

    msg_dispatch_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    function automatic bit type_known(input logic [7:0] t);
        return (t == 8'h41) || (t == 8'h44) || (t == 8'h45) || (t == 8'h58);
    endfunction

    function automatic logic [1:0] kind_of(input logic [7:0] t);
        case (t)
            8'h41:   return 2'd0;
            8'h44:   return 2'd1;
            8'h45:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic msg_t rand_msg(input logic [7:0] t);
        msg_t m;
        m.typ   = t;
        m.stock = 8'($urandom);
        m.order = $urandom;
        m.price = $urandom;
        m.qty   = $urandom;
        return m;
    endfunction

    // One clock of stimulus: present the fields of the message whose done
    // went high last cycle, optionally raise done for the next message.
    task automatic cycle(input bit done, input msg_t nxt);
        exp_t e;
        bus_if.in_msg_type = pend.typ;
        bus_if.in_stock_id = pend.stock;
        bus_if.in_order_id = pend.order;
        bus_if.in_price    = pend.price;
        bus_if.in_quantity = pend.qty;
        bus_if.in_done     = done;
        if (done) begin
            pend = nxt;
            if (type_known(nxt.typ)) begin
                e = {kind_of(nxt.typ), nxt.stock, nxt.order, nxt.price, nxt.qty};
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: head must match the oldest expected entry.
    always @(negedge clk) begin
        if (mon_en && !reset && bus_if.out_valid) begin
            total++;
            got_e = {bus_if.out_kind, bus_if.out_stock_id, bus_if.out_order_id,
                     bus_if.out_price, bus_if.out_quantity};
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL mon_unexpected: got out_valid=1 head=%h, expected no output", got_e);
            end else begin
                if (got_e !== sb_q[0]) begin
                    bad++;
                    $display("FAIL mon_head: got %h, expected %h", got_e, sb_q[0]);
                end
                if (bus_if.out_ready) begin
                    mon_e = sb_q.pop_front();
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus_if.out_valid, bus_if.fifo_level, bus_if.drop_count, bus_if.bad_type_count} !== '0) begin
            bad++;
            $display("FAIL reset_state: got valid=%0b level=%0d drop=%0d badtype=%0d, expected all 0",
                     bus_if.out_valid, bus_if.fifo_level, bus_if.drop_count, bus_if.bad_type_count);
        end
        total++;
        if ({bus_if.out_kind, bus_if.out_order_id, bus_if.out_price} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got kind=%0d order=%h price=%h, expected 0",
                     bus_if.out_kind, bus_if.out_order_id, bus_if.out_price);
        end
        reset = 1'b0;
        cycle(1'b0, pend);
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        msg_t m;
        m = '{typ: 8'h41, stock: 8'h07, order: 32'h11223344, price: 32'd1000, qty: 32'd50};
        bus_if.out_ready = 1'b0;
        cycle(1'b1, m);
        total++;
        if (bus_if.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early: got out_valid=%0b one cycle after done, expected 0", bus_if.out_valid);
        end
        cycle(1'b0, m);
        total++;
        if (bus_if.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_latency: got out_valid=%0b two cycles after done, expected 1", bus_if.out_valid);
        end
        total++;
        if ({bus_if.out_kind, bus_if.out_stock_id, bus_if.out_order_id, bus_if.out_price, bus_if.out_quantity}
            !== {2'd0, 8'h07, 32'h11223344, 32'd1000, 32'd50}) begin
            bad++;
            $display("FAIL single_fields: got kind=%0d stock=%h order=%h price=%0d qty=%0d, expected 0 07 11223344 1000 50",
                     bus_if.out_kind, bus_if.out_stock_id, bus_if.out_order_id, bus_if.out_price, bus_if.out_quantity);
        end
        total++;
        if (bus_if.fifo_level !== 4'd1) begin
            bad++;
            $display("FAIL single_level: got %0d, expected 1", bus_if.fifo_level);
        end
        bus_if.out_ready = 1'b1;
        repeat (3) cycle(1'b0, m);
        total++;
        if (bus_if.fifo_level !== 4'd0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL single_drain: got level=%0d pending=%0d, expected 0 0", bus_if.fifo_level, sb_q.size());
        end
    endtask

    task automatic test_types();
        logic [7:0] seq [4] = '{8'h44, 8'h45, 8'h58, 8'h5A};
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, rand_msg(seq[i]));
        end
        repeat (6) cycle(1'b0, pend);
        total++;
        if (bus_if.bad_type_count !== 16'd1 || bus_if.drop_count !== 16'd0) begin
            bad++;
            $display("FAIL types_counts: got badtype=%0d drop=%0d, expected 1 0",
                     bus_if.bad_type_count, bus_if.drop_count);
        end
        total++;
        if (bus_if.fifo_level !== 4'd0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL types_drain: got level=%0d pending=%0d, expected 0 0", bus_if.fifo_level, sb_q.size());
        end
    endtask

    task automatic test_overflow();
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            cycle(1'b1, rand_msg(good_types[i % 4]));
        end
        cycle(1'b0, pend);
        cycle(1'b0, pend);
        // The last two never enter the FIFO.
        mon_e = sb_q.pop_back();
        mon_e = sb_q.pop_back();
        total++;
        if (bus_if.fifo_level !== 4'(DEPTH) || bus_if.drop_count !== 16'd2) begin
            bad++;
            $display("FAIL overflow_full: got level=%0d drop=%0d, expected %0d 2",
                     bus_if.fifo_level, bus_if.drop_count, DEPTH);
        end
        repeat (4) cycle(1'b0, pend);  // stalled: monitor checks head stays put
        bus_if.out_ready = 1'b1;
        repeat (DEPTH + 3) cycle(1'b0, pend);
        total++;
        if (bus_if.fifo_level !== 4'd0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL overflow_drain: got level=%0d pending=%0d, expected 0 0", bus_if.fifo_level, sb_q.size());
        end
    endtask

    task automatic test_full_push_pop();
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, rand_msg(good_types[(i + 1) % 4]));
        end
        cycle(1'b0, pend);
        cycle(1'b0, pend);
        total++;
        if (bus_if.fifo_level !== 4'(DEPTH)) begin
            bad++;
            $display("FAIL pp_fill: got level=%0d, expected %0d", bus_if.fifo_level, DEPTH);
        end
        cycle(1'b1, rand_msg(8'h58));
        bus_if.out_ready = 1'b1;       // pop on the same edge the push lands
        cycle(1'b0, pend);
        bus_if.out_ready = 1'b0;
        total++;
        if (bus_if.fifo_level !== 4'(DEPTH) || bus_if.drop_count !== 16'd2) begin
            bad++;
            $display("FAIL pp_same_edge: got level=%0d drop=%0d, expected %0d 2",
                     bus_if.fifo_level, bus_if.drop_count, DEPTH);
        end
        bus_if.out_ready = 1'b1;
        repeat (DEPTH + 3) cycle(1'b0, pend);
        total++;
        if (bus_if.fifo_level !== 4'd0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL pp_drain: got level=%0d pending=%0d, expected 0 0", bus_if.fifo_level, sb_q.size());
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int cyc  = 0;
        while (sent < 3 * DEPTH) begin
            bus_if.out_ready = cyc[0];
            if ((cyc % 8) < 4) begin
                cycle(1'b1, rand_msg(good_types[$urandom_range(0, 3)]));
                sent++;
            end else begin
                cycle(1'b0, pend);
            end
            cyc++;
        end
        bus_if.out_ready = 1'b0;
        cycle(1'b0, pend);
        cycle(1'b0, pend);
        total++;
        if (int'(bus_if.fifo_level) != sb_q.size()) begin
            bad++;
            $display("FAIL wrap_level: got level=%0d, expected %0d", bus_if.fifo_level, sb_q.size());
        end
        bus_if.out_ready = 1'b1;
        repeat (DEPTH + 3) cycle(1'b0, pend);
        total++;
        if (bus_if.fifo_level !== 4'd0 || sb_q.size() != 0 || bus_if.drop_count !== 16'd2) begin
            bad++;
            $display("FAIL wrap_drain: got level=%0d pending=%0d drop=%0d, expected 0 0 2",
                     bus_if.fifo_level, sb_q.size(), bus_if.drop_count);
        end
    endtask

    task automatic test_reset_mid();
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, rand_msg(8'h41));
        end
        cycle(1'b0, pend);
        cycle(1'b1, rand_msg(8'h45));  // capture pending on the next edge
        reset = 1'b1;
        #1;
        total++;
        if ({bus_if.out_valid, bus_if.fifo_level, bus_if.drop_count, bus_if.bad_type_count} !== '0) begin
            bad++;
            $display("FAIL midreset_state: got valid=%0b level=%0d drop=%0d badtype=%0d, expected all 0",
                     bus_if.out_valid, bus_if.fifo_level, bus_if.drop_count, bus_if.bad_type_count);
        end
        sb_q.delete();
        cycle(1'b0, pend);
        cycle(1'b0, pend);
        reset = 1'b0;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, pend);
            total++;
            if (bus_if.out_valid !== 1'b0 || bus_if.fifo_level !== 4'd0) begin
                bad++;
                $display("FAIL midreset_stale: cycle %0d got valid=%0b level=%0d, expected 0 0",
                         i, bus_if.out_valid, bus_if.fifo_level);
            end
        end
    endtask

    initial begin
        bus_if.in_done     = 1'b0;
        bus_if.in_msg_type = 8'h00;
        bus_if.in_stock_id = 8'h00;
        bus_if.in_order_id = 32'h0;
        bus_if.in_price    = 32'h0;
        bus_if.in_quantity = 32'h0;
        bus_if.out_ready   = 1'b0;
        test_reset();
        test_single();
        test_types();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
